// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front end: FSM states, FIFO entry
// layout and Wishbone constants.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      HALT
   } fetch_state_t;

   localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
      logic        err;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order prefetch FIFO of fetch entries with a registered head, flush
// and an occupancy count.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  fetch_entry_t               data_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   output fetch_entry_t               head_o,
   output logic                       valid_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   fetch_entry_t  mem_q [DEPTH];
   fetch_entry_t  head_q, head_d;
   logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          valid_q;
   logic          do_pop;

   assign do_pop = pop_i && (cnt_q != '0);

   // The head is precomputed for the next cycle; when the FIFO drains to
   // empty in the same cycle as a push, the incoming entry bypasses storage.
   always_comb begin
      rd_d   = rd_q;
      wr_d   = wr_q;
      cnt_d  = cnt_q;
      head_d = '0;
      if (flush_i) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_pop) rd_d = rd_q + AW'(1);
         if (push_i) wr_d = wr_q + AW'(1);
         cnt_d = cnt_q + CW'(push_i) - CW'(do_pop);
         if (cnt_d != '0) begin
            if (push_i && (rd_d == wr_q)) head_d = data_i;
            else                          head_d = mem_q[rd_d];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_q    <= '0;
         wr_q    <= '0;
         cnt_q   <= '0;
         head_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
         head_q  <= head_d;
         valid_q <= (cnt_d != '0);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i && !flush_i) mem_q[wr_q] <= data_i;
   end

   assign head_o  = head_q;
   assign valid_o = valid_q;
   assign count_o = cnt_q;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch unit: Wishbone B4 classic read master feeding an
// in-order prefetch FIFO, with redirect, retry limiting and bus-error markers.
module fetch_prefetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned RETRY_LIMIT  = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ACK_I,
   input  logic        ERR_I,
   input  logic        RTY_I,
   input  logic [31:0] DAT_I,
   output logic        STB_O,
   output logic        CYC_O,
   output logic [31:0] ADR_O,
   output logic [31:0] DAT_O,
   output logic        WE_O,
   output logic [2:0]  CTI_O,
   output logic [31:0] ins_o,
   output logic [31:0] pc_o,
   output logic        err_o,
   output logic        valid_o,
   input  logic        ready_i,
   output logic        stall_o,
   input  logic        jmp_i,
   input  logic [31:0] jmp_addr_i
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned RW = $clog2(RETRY_LIMIT + 2);

   fetch_state_t  state_q;
   logic [31:0]   pc_q;
   logic [31:0]   adr_q;
   logic [RW-1:0] retry_q;
   logic          cyc_q, stb_q;

   fetch_entry_t  head, push_data;
   logic          push, pop, fifo_valid;
   logic [CW-1:0] fifo_cnt;
   logic          active, bus_err, retry_last, room_after_ack;

   assign active         = (state_q == REQ) && stb_q;
   assign pop            = fifo_valid && ready_i;
   assign retry_last     = (32'(retry_q) + 32'd1) >= RETRY_LIMIT;
   assign bus_err        = active && (ERR_I || (RTY_I && retry_last));
   assign push           = !jmp_i && ((active && ACK_I) || bus_err);
   assign room_after_ack = (32'(fifo_cnt) + 32'd1 - 32'(pop)) < FIFO_DEPTH;

   always_comb begin
      push_data     = '0;
      push_data.pc  = pc_q;
      if (active && ACK_I) push_data.ins = DAT_I;
      else                 push_data.err = 1'b1;
   end

   // REQ with STB low is the one-cycle gap before (re)issuing pc_q, used
   // both after a retry and after a redirect.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_VECTOR;
         adr_q   <= RESET_VECTOR;
         retry_q <= '0;
         cyc_q   <= 1'b0;
         stb_q   <= 1'b0;
      end else if (jmp_i) begin
         state_q <= REQ;
         pc_q    <= word_align(jmp_addr_i);
         adr_q   <= word_align(jmp_addr_i);
         retry_q <= '0;
         cyc_q   <= 1'b0;
         stb_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (32'(fifo_cnt) < FIFO_DEPTH) begin
                  state_q <= REQ;
                  cyc_q   <= 1'b1;
                  stb_q   <= 1'b1;
                  adr_q   <= pc_q;
               end
            end
            REQ: begin
               if (!stb_q) begin
                  cyc_q <= 1'b1;
                  stb_q <= 1'b1;
                  adr_q <= pc_q;
               end else if (ACK_I) begin
                  retry_q <= '0;
                  pc_q    <= pc_q + 32'd4;
                  adr_q   <= pc_q + 32'd4;
                  if (!room_after_ack) begin
                     state_q <= IDLE;
                     cyc_q   <= 1'b0;
                     stb_q   <= 1'b0;
                  end
               end else if (bus_err) begin
                  retry_q <= '0;
                  state_q <= HALT;
                  cyc_q   <= 1'b0;
                  stb_q   <= 1'b0;
               end else if (RTY_I) begin
                  retry_q <= retry_q + RW'(1);
                  stb_q   <= 1'b0;
               end
            end
            HALT: begin
               cyc_q <= 1'b0;
               stb_q <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               cyc_q   <= 1'b0;
               stb_q   <= 1'b0;
            end
         endcase
      end
   end

   fetch_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (push),
      .data_i  (push_data),
      .pop_i   (pop),
      .flush_i (jmp_i),
      .head_o  (head),
      .valid_o (fifo_valid),
      .count_o (fifo_cnt)
   );

   assign STB_O   = stb_q;
   assign CYC_O   = cyc_q;
   assign ADR_O   = adr_q;
   assign DAT_O   = '0;
   assign WE_O    = 1'b0;
   assign CTI_O   = WB_CTI_CLASSIC;
   assign ins_o   = head.ins;
   assign pc_o    = head.pc;
   assign err_o   = head.err;
   assign valid_o = fifo_valid;
   assign stall_o = !fifo_valid;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed and randomized bench for fetch_prefetch_unit against a queue-based
// model of the prefetch stream.
module tb_fetch_prefetch_unit;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned LIMIT = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ACK_I = 1'b0, ERR_I = 1'b0, RTY_I = 1'b0;
   logic [31:0] DAT_I = '0;
   logic        STB_O, CYC_O, WE_O;
   logic [31:0] ADR_O, DAT_O;
   logic [2:0]  CTI_O;
   logic [31:0] ins_o, pc_o;
   logic        err_o, valid_o, stall_o;
   logic        ready_i = 1'b0;
   logic        jmp_i = 1'b0;
   logic [31:0] jmp_addr_i = '0;

   always #5 clk = ~clk;

   fetch_prefetch_unit #(
      .RESET_VECTOR(32'h0000_0000),
      .FIFO_DEPTH  (DEPTH),
      .RETRY_LIMIT (LIMIT)
   ) dut (
      .clk(clk), .rst(rst),
      .ACK_I(ACK_I), .ERR_I(ERR_I), .RTY_I(RTY_I), .DAT_I(DAT_I),
      .STB_O(STB_O), .CYC_O(CYC_O), .ADR_O(ADR_O), .DAT_O(DAT_O),
      .WE_O(WE_O), .CTI_O(CTI_O),
      .ins_o(ins_o), .pc_o(pc_o), .err_o(err_o), .valid_o(valid_o),
      .ready_i(ready_i), .stall_o(stall_o),
      .jmp_i(jmp_i), .jmp_addr_i(jmp_addr_i)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
      logic        err;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_pc = '0;
   bit          m_halt = 1'b0;
   int unsigned m_rty = 0;
   int unsigned idle_run = 0;
   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_bus();
      ACK_I = 1'b0; ERR_I = 1'b0; RTY_I = 1'b0; jmp_i = 1'b0;
   endtask

   // One clock: advance the model with the inputs seen at the edge, then compare.
   task automatic cycle();
      logic        stb_p, ack_p, err_p, rty_p, rst_p, jmp_p, rdy_p;
      logic [31:0] dat_p, ja_p;
      stb_p = STB_O; ack_p = ACK_I; err_p = ERR_I; rty_p = RTY_I;
      rst_p = rst; jmp_p = jmp_i; rdy_p = ready_i; dat_p = DAT_I; ja_p = jmp_addr_i;
      @(posedge clk);
      #1;
      if (rst_p) begin
         mq.delete(); m_pc = '0; m_halt = 1'b0; m_rty = 0; idle_run = 0;
      end else begin
         if (jmp_p) begin
            mq.delete(); m_pc = {ja_p[31:2], 2'b00}; m_halt = 1'b0; m_rty = 0;
         end else begin
            if (mq.size() > 0 && rdy_p) void'(mq.pop_front());
            if (stb_p && ack_p) begin
               mq.push_back('{m_pc, dat_p, 1'b0});
               m_pc  = m_pc + 32'd4;
               m_rty = 0;
            end else if (stb_p && (err_p || rty_p)) begin
               if (rty_p) m_rty++;
               if (err_p || m_rty >= LIMIT) begin
                  mq.push_back('{m_pc, 32'd0, 1'b1});
                  m_halt = 1'b1;
                  m_rty  = 0;
               end
            end
         end
         chk("valid", 32'(valid_o), 32'(mq.size() != 0));
         chk("stall", 32'(stall_o), 32'(mq.size() == 0));
         if (mq.size() != 0) begin
            chk("head_pc", pc_o, mq[0].pc);
            chk("head_ins", ins_o, mq[0].ins);
            chk("head_err", 32'(err_o), 32'(mq[0].err));
         end
         if (STB_O) begin
            chk("fetch_adr", ADR_O, m_pc);
            chk("fetch_cyc", 32'(CYC_O), 32'd1);
            chk("fetch_room", 32'(mq.size() < DEPTH), 32'd1);
         end
         if (m_halt) chk("halt_cyc", 32'(CYC_O), 32'd0);
         idle_run = (!m_halt && mq.size() < DEPTH && !STB_O) ? idle_run + 1 : 0;
         chk("fetch_live", 32'(idle_run <= 2), 32'd1);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; clear_bus(); ready_i = 1'b0;
      cycle(); cycle();
      rst = 1'b0;
   endtask

   task automatic wait_stb(input string tag);
      int unsigned k = 0;
      while (!STB_O && k < 10) begin cycle(); k++; end
      chk(tag, 32'(STB_O), 32'd1);
   endtask

   initial begin
      logic [31:0] d [4];
      logic [31:0] seen;
      int unsigned n;

      // Reset values and first request timing
      rst = 1'b1; clear_bus(); ready_i = 1'b0;
      cycle(); cycle();
      chk("rst_stb", 32'(STB_O), 32'd0);
      chk("rst_cyc", 32'(CYC_O), 32'd0);
      chk("rst_adr", ADR_O, 32'h0);
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_stall", 32'(stall_o), 32'd1);
      chk("rst_err", 32'(err_o), 32'd0);
      chk("rst_ins", ins_o, 32'h0);
      chk("rst_pc", pc_o, 32'h0);
      chk("tie_dat", DAT_O, 32'h0);
      chk("tie_we", 32'(WE_O), 32'd0);
      chk("tie_cti", 32'(CTI_O), 32'd0);
      rst = 1'b0;
      cycle();
      chk("first_cyc", 32'(CYC_O), 32'd1);
      chk("first_adr", ADR_O, 32'h0);

      // Zero-wait slave, decode always ready
      ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ACK_I = 1'b1; d[i] = $urandom; DAT_I = d[i];
         cycle();
         chk("zw_adr", ADR_O, 32'(4 * (i + 1)));
         chk("zw_pc", pc_o, 32'(4 * i));
         chk("zw_ins", ins_o, d[i]);
         chk("zw_valid", 32'(valid_o), 32'd1);
      end
      ACK_I = 1'b0;

      // Decode stalled: fill exactly FIFO_DEPTH, then one pop frees one fetch
      do_reset();
      n = 0;
      for (int i = 0; i < 12; i++) begin
         ACK_I = STB_O; DAT_I = $urandom;
         if (STB_O) n++;
         cycle();
      end
      ACK_I = 1'b0;
      chk("fill_acks", n, DEPTH);
      chk("fill_cyc", 32'(CYC_O), 32'd0);
      chk("fill_pc", pc_o, 32'h0);
      ready_i = 1'b1;
      cycle();
      ready_i = 1'b0;
      chk("pop_pc", pc_o, 32'h4);
      n = 0; seen = 32'hDEAD_BEEF;
      for (int i = 0; i < 8; i++) begin
         ACK_I = STB_O; DAT_I = $urandom;
         if (STB_O) begin n++; seen = ADR_O; end
         cycle();
      end
      ACK_I = 1'b0;
      chk("refill_acks", n, 32'd1);
      chk("refill_adr", seen, 32'h10);

      // Redirect in the same cycle as an ACK
      do_reset();
      wait_stb("jmp_wait");
      ACK_I = 1'b1; DAT_I = $urandom; cycle();
      ACK_I = 1'b1; DAT_I = $urandom; cycle();
      ACK_I = 1'b1; DAT_I = 32'hBAD0_BAD0; jmp_i = 1'b1; jmp_addr_i = 32'h103;
      cycle();
      clear_bus();
      chk("jmp_cyc0", 32'(CYC_O), 32'd0);
      chk("jmp_valid0", 32'(valid_o), 32'd0);
      cycle();
      chk("jmp_cyc1", 32'(CYC_O), 32'd1);
      chk("jmp_adr", ADR_O, 32'h100);
      chk("jmp_valid1", 32'(valid_o), 32'd0);
      ACK_I = 1'b1; d[0] = $urandom; DAT_I = d[0];
      cycle();
      ACK_I = 1'b0;
      chk("jmp_head_pc", pc_o, 32'h100);
      chk("jmp_head_ins", ins_o, d[0]);

      // Retry limit on 0x20 turns into an error marker and halts
      do_reset();
      ready_i = 1'b1;
      wait_stb("rty_wait");
      for (int i = 0; i < 8; i++) begin
         ACK_I = 1'b1; DAT_I = $urandom; cycle();
      end
      ACK_I = 1'b0;
      chk("rty_adr", ADR_O, 32'h20);
      for (int r = 0; r < 3; r++) begin
         RTY_I = 1'b1; cycle(); RTY_I = 1'b0;
         if (r < 2) begin
            chk("rty_gap", 32'(STB_O), 32'd0);
            cycle();
            chk("rty_reissue", ADR_O, 32'h20);
         end
      end
      ready_i = 1'b0;
      chk("rty_err", 32'(err_o), 32'd1);
      chk("rty_pc", pc_o, 32'h20);
      chk("rty_ins", ins_o, 32'h0);
      chk("rty_halt", 32'(CYC_O), 32'd0);
      repeat (4) cycle();
      chk("rty_still_halt", 32'(CYC_O), 32'd0);
      jmp_i = 1'b1; jmp_addr_i = 32'h40; cycle(); jmp_i = 1'b0;
      cycle();
      chk("rty_resume_cyc", 32'(CYC_O), 32'd1);
      chk("rty_resume_adr", ADR_O, 32'h40);

      // Bus error on 0x8
      do_reset();
      wait_stb("err_wait");
      ACK_I = 1'b1; DAT_I = $urandom; cycle();
      ACK_I = 1'b1; DAT_I = $urandom; cycle();
      ACK_I = 1'b0; ERR_I = 1'b1; cycle(); ERR_I = 1'b0;
      chk("err_cyc", 32'(CYC_O), 32'd0);
      n = 0;
      for (int i = 0; i < 5; i++) begin
         if (STB_O) n++;
         cycle();
      end
      chk("err_no_fetch", n, 32'd0);
      chk("err_e0_pc", pc_o, 32'h0);
      chk("err_e0_err", 32'(err_o), 32'd0);
      ready_i = 1'b1; cycle();
      chk("err_e1_pc", pc_o, 32'h4);
      chk("err_e1_err", 32'(err_o), 32'd0);
      cycle(); ready_i = 1'b0;
      chk("err_e2_pc", pc_o, 32'h8);
      chk("err_e2_err", 32'(err_o), 32'd1);
      chk("err_e2_ins", ins_o, 32'h0);

      // Address wrap at the top of memory
      jmp_i = 1'b1; jmp_addr_i = 32'hFFFF_FFFE; cycle(); jmp_i = 1'b0;
      cycle();
      chk("wrap_adr0", ADR_O, 32'hFFFF_FFFC);
      ready_i = 1'b1; ACK_I = 1'b1; DAT_I = $urandom; cycle(); ACK_I = 1'b0;
      chk("wrap_adr1", ADR_O, 32'h0);
      chk("wrap_pc", pc_o, 32'hFFFF_FFFC);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         int unsigned r;
         clear_bus();
         ready_i = ($urandom_range(0, 3) != 0);
         DAT_I = $urandom;
         if (STB_O) begin
            r = $urandom_range(0, 99);
            if (r < 65)      ACK_I = 1'b1;
            else if (r < 75) RTY_I = 1'b1;
            else if (r < 78) ERR_I = 1'b1;
         end
         if ($urandom_range(0, 39) == 0 || (m_halt && $urandom_range(0, 3) == 0)) begin
            jmp_i = 1'b1;
            jmp_addr_i = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                     : $urandom;
         end
         cycle();
      end
      clear_bus();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
